alu_decode: RTL and testbench

//  Decode/issue stage that feeds the ALU. Accepts 32-bit RV32I instructions on a

---
 rtl/alu_decode.sv | 172 +++++++++++++++++
 tb/tb_alu_decode.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode.sv
// Decode/issue stage for RV32I OP and OP-IMM: turns an instruction plus register
// read data into an ALU bundle, buffered through a two-entry skid stage.
module alu_decode #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  rs1,
  output logic [XLEN-1:0]  rs2,
  output logic [2:0]       funct3,
  output logic             funct7,
  output logic [4:0]       rd_addr,
  output logic             illegal,
  output logic [CNT_W-1:0] issued_cnt
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic            illegal;
    logic [4:0]      rd;
    logic            f7;
    logic [2:0]      f3;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] a;
  } bundle_t;

  state_t           state_reg, state_next;
  bundle_t          main_reg, main_next;
  bundle_t          skid_reg, skid_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  bundle_t          dec;
  logic [XLEN-1:0]  imm_sext;
  logic             in_fire, out_fire;

  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  genvar gi;
  generate
    for (gi = 0; gi < XLEN; gi++) begin : g_sext
      if (gi < 12) begin : g_low
        assign imm_sext[gi] = instr[20+gi];
      end else begin : g_high
        assign imm_sext[gi] = instr[31];
      end
    end
  endgenerate

  // Illegal tokens still travel down the pipe, but with every payload field zeroed.
  always_comb begin
    logic legal;
    logic alt;
    logic [XLEN-1:0] opb;
    legal = 1'b0;
    alt   = 1'b0;
    opb   = '0;
    dec   = '0;
    case (instr[6:0])
      OPC_OP: begin
        opb   = rs2_data;
        alt   = instr[30];
        legal = (instr[31:25] == F7_ZERO) ||
                ((instr[31:25] == F7_ALT) &&
                 ((instr[14:12] == 3'b000) || (instr[14:12] == 3'b101)));
      end
      OPC_OPIMM: begin
        opb = imm_sext;
        case (instr[14:12])
          3'b001: begin
            legal = (instr[31:25] == F7_ZERO);
            alt   = 1'b0;
          end
          3'b101: begin
            legal = (instr[31:25] == F7_ZERO) || (instr[31:25] == F7_ALT);
            alt   = instr[30];
          end
          default: begin
            legal = 1'b1;
            alt   = 1'b0;
          end
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (legal) begin
      dec.a  = rs1_data;
      dec.b  = opb;
      dec.f3 = instr[14:12];
      dec.f7 = alt;
      dec.rd = instr[11:7];
    end else begin
      dec.illegal = 1'b1;
    end
  end

  assign in_ready  = (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
      cnt_reg   <= cnt_next;
    end
  end

  // main_reg always holds the oldest entry; skid_reg only fills when main is stalled.
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    cnt_next   = cnt_reg + {{(CNT_W-1){1'b0}}, out_fire};
    case (state_reg)
      EMPTY: begin
        if (in_fire) begin
          state_next = ONE;
          main_next  = dec;
        end
      end
      ONE: begin
        if (in_fire && !out_fire) begin
          state_next = FULL;
          skid_next  = dec;
        end else if (out_fire && !in_fire) begin
          state_next = EMPTY;
        end else if (in_fire && out_fire) begin
          main_next = dec;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_next = ONE;
          main_next  = skid_reg;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  assign rs1        = main_reg.a;
  assign rs2        = main_reg.b;
  assign funct3     = main_reg.f3;
  assign funct7     = main_reg.f7;
  assign rd_addr    = main_reg.rd;
  assign illegal    = main_reg.illegal;
  assign issued_cnt = cnt_reg;

endmodule

// File: tb/tb_alu_decode.sv
// Scoreboard bench for alu_decode: driver pushes hand-computed bundles, a
// negedge monitor pops and compares on every output handshake.
module tb_alu_decode;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic        ill;
    logic [4:0]  rd;
    logic        f7;
    logic [2:0]  f3;
    logic [31:0] b;
    logic [31:0] a;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      instr = '0;
  logic [4:0]       rs1_addr, rs2_addr;
  logic [31:0]      rs1_data = '0;
  logic [31:0]      rs2_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      rs1, rs2;
  logic [2:0]       funct3;
  logic             funct7;
  logic [4:0]       rd_addr;
  logic             illegal;
  logic [CNT_W-1:0] issued_cnt;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  alu_decode #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .rd_addr(rd_addr), .illegal(illegal), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic ill, input logic [4:0] rd, input logic f7,
                              input logic [2:0] f3, input logic [31:0] b, input logic [31:0] a);
    exp_t e;
    e.ill = ill; e.rd = rd; e.f7 = f7; e.f3 = f3; e.b = b; e.a = a;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  // Monitor: a handshake seen at the negedge completes on the following posedge.
  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      got = mk(illegal, rd_addr, funct7, funct3, rs2, rs1);
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL bundle: unexpected output rs1=%h rs2=%h rd=%0d", rs1, rs2, rd_addr);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL bundle: got ill=%0d rd=%0d f7=%0d f3=%0d rs2=%h rs1=%h expected ill=%0d rd=%0d f7=%0d f3=%0d rs2=%h rs1=%h",
                   got.ill, got.rd, got.f7, got.f3, got.b, got.a, e.ill, e.rd, e.f7, e.f3, e.b, e.a);
        end else begin
          $display("ok   bundle: ill=%0d rd=%0d f7=%0d f3=%0d rs2=%h rs1=%h",
                   got.ill, got.rd, got.f7, got.f3, got.b, got.a);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2, input exp_t e);
    int waited;
    waited   = 0;
    instr    = ins;
    rs1_data = d1;
    rs2_data = d2;
    in_valid = 1'b1;
    #1;
    chk("rs_addr", {22'd0, rs2_addr, rs1_addr}, {22'd0, ins[24:20], ins[19:15]});
    while (!in_ready && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready stuck at 0 for instr %h", ins);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      sb.push_back(e);
      exp_cnt++;
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || out_valid) && w < 200) begin
      @(posedge clk);
      w++;
    end
    #1;
    if (w >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d entries still pending", sb.size());
    end
  endtask

  initial begin
    #3;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_cnt", {28'd0, issued_cnt}, 32'd0);
    chk("reset_bundle", rs1 | rs2 | {26'd0, illegal, rd_addr}, 32'd0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-pressure: two accepts fill the stage, the head bundle holds still.
    out_ready = 1'b0;
    send(32'h002081B3, 32'd20, 32'd30, mk(0, 5'd3, 0, 3'b000, 32'd30, 32'd20));
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    send(32'h402081B3, 32'd100, 32'd7, mk(0, 5'd3, 1, 3'b000, 32'd7, 32'd100));
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_rs1", rs1, 32'd20);
    chk("hold_rs2", rs2, 32'd30);
    chk("hold_rd", {27'd0, rd_addr}, 32'd3);
    out_ready = 1'b1;
    send(32'hFFF08193, 32'd5, 32'h1234, mk(0, 5'd3, 0, 3'b000, 32'hFFFFFFFF, 32'd5));
    drain();
    chk("cnt_after_bp", {28'd0, issued_cnt}, 32'd3);

    // Directed decode vectors, streamed back to back.
    send(32'h4030D293, 32'h80000000, 32'd9, mk(0, 5'd5, 1, 3'b101, 32'h00000403, 32'h80000000));
    send(32'h40309293, 32'd11, 32'd12, mk(1, 5'd0, 0, 3'b000, 32'd0, 32'd0));
    send(32'h0000A183, 32'd13, 32'd14, mk(1, 5'd0, 0, 3'b000, 32'd0, 32'd0));
    send(32'h4020E3B3, 32'd15, 32'd16, mk(1, 5'd0, 0, 3'b000, 32'd0, 32'd0));
    send(32'h40735233, 32'hF0000000, 32'd4, mk(0, 5'd4, 1, 3'b101, 32'd4, 32'hF0000000));
    send(32'h7FF1A113, 32'd17, 32'd18, mk(0, 5'd2, 0, 3'b010, 32'h000007FF, 32'd17));
    send(32'h022081B3, 32'd19, 32'd21, mk(1, 5'd0, 0, 3'b000, 32'd0, 32'd0));

    // ADDI sweep with intermittent stalls; pushes the counter past its wrap.
    for (int i = 0; i < 8; i++) begin
      int v;
      logic [31:0] ins;
      v = i * 300 - 1000;
      ins = {v[11:0], 5'd1, 3'b000, 5'(i + 1), 7'b0010011};
      out_ready = (i % 3) != 0;
      send(ins, 32'h1000 + i, 32'hDEAD, mk(0, 5'(i + 1), 0, 3'b000, 32'(v), 32'h1000 + i));
    end
    out_ready = 1'b1;
    drain();
    chk("cnt_wrap", {28'd0, issued_cnt}, {28'd0, 4'(exp_cnt)});

    // Reset while FULL drops both entries.
    out_ready = 1'b0;
    send(32'h002081B3, 32'd1, 32'd2, mk(0, 5'd3, 0, 3'b000, 32'd2, 32'd1));
    send(32'h002081B3, 32'd3, 32'd4, mk(0, 5'd3, 0, 3'b000, 32'd4, 32'd3));
    chk("prereset_in_ready", {31'd0, in_ready}, 32'd0);
    #1 rst_n = 1'b0;
    sb.delete();
    exp_cnt = 0;
    #1;
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midreset_cnt", {28'd0, issued_cnt}, 32'd0);
    chk("midreset_rs1", rs1, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postreset_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    send(32'h402081B3, 32'd50, 32'd8, mk(0, 5'd3, 1, 3'b000, 32'd8, 32'd50));
    drain();
    chk("cnt_after_reset", {28'd0, issued_cnt}, 32'd1);
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
